pipelined_addsub: RTL

Parametrised, carry-segmented pipelined adder/subtractor for the MaxNet datapath. It generalises the single-cycle ripple adder into WIDTH bits split across STAGES registered carry segments, adds a per-operation add/subtract mode, a valid/ready handshake with back-pressure, and carry/overflow flags. It sits between the weight-multiply stage and the MaxNet comparator/accumulator and sustains one operation per cycle when not stalled.

---
 rtl/sum_pkg.sv | 20 ++
 rtl/Full_adder.sv | 13 +
 rtl/adder_segment.sv | 33 +++
 rtl/pipelined_addsub.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Saturation is enabled by defining PIPELINED_ADDSUB_SAT_EN.
package sum_pkg;

  localparam int    MAX_WIDTH = 64;
  localparam string SAT_MACRO = "PIPELINED_ADDSUB_SAT_EN";

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/Full_adder.sv
// One-bit full adder cell used to build the ripple segments.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry adder: one carry segment of the pipeline.
module adder_segment
  import sum_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < SEG; gi++) begin : g_fa
      Full_adder u_fa (
        .a   (a[gi]),
        .b   (b[gi]),
        .cin (c[gi]),
        .s   (s[gi]),
        .cout(c[gi+1])
      );
    end
  endgenerate

  assign cout = c[SEG];

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-segmented pipelined adder/subtractor with valid/ready flow control.
// Define PIPELINED_ADDSUB_SAT_EN to clamp overflowing results in the final stage.
module pipelined_addsub
  import sum_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  logic              en;
  logic [WIDTH-1:0]  b_inv;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  seg_s;
  logic [WIDTH-1:0]  sum_next;
  logic [WIDTH-1:0]  sum_fin;
  logic [STAGES-1:0] cin_w;
  logic [STAGES-1:0] cout_w;
  logic [STAGES-1:0] vld_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              carry_reg;
  logic              ovf_reg;
  logic              ovf_next;

  assign en       = ~vld_reg[STAGES-1] | out_ready;
  assign in_ready = en;
  assign b_inv    = b ^ {WIDTH{sub}};
  assign cin_w[0] = sub;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_seg
      localparam int LO = gi * SEG;

      // Operand slices for segment gi wait gi cycles so they meet the carry of the same beat.
      if (gi == 0) begin : g_head
        assign op_a[LO +: SEG] = a[LO +: SEG];
        assign op_b[LO +: SEG] = b_inv[LO +: SEG];
      end else begin : g_skew
        logic [SEG-1:0] a_sk_reg [gi];
        logic [SEG-1:0] b_sk_reg [gi];
        logic           cy_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < gi; j++) begin
              a_sk_reg[j] <= '0;
              b_sk_reg[j] <= '0;
            end
            cy_reg <= 1'b0;
          end else if (en) begin
            a_sk_reg[0] <= a[LO +: SEG];
            b_sk_reg[0] <= b_inv[LO +: SEG];
            for (int j = 1; j < gi; j++) begin
              a_sk_reg[j] <= a_sk_reg[j-1];
              b_sk_reg[j] <= b_sk_reg[j-1];
            end
            cy_reg <= cout_w[gi-1];
          end
        end

        assign op_a[LO +: SEG] = a_sk_reg[gi-1];
        assign op_b[LO +: SEG] = b_sk_reg[gi-1];
        assign cin_w[gi]       = cy_reg;
      end

      adder_segment #(.SEG(SEG)) u_seg (
        .a   (op_a[LO +: SEG]),
        .b   (op_b[LO +: SEG]),
        .cin (cin_w[gi]),
        .s   (seg_s[LO +: SEG]),
        .cout(cout_w[gi])
      );

      // Lower slices are held back so every slice lands in the output register together.
      if (gi == STAGES - 1) begin : g_tail
        assign sum_next[LO +: SEG] = seg_s[LO +: SEG];
      end else begin : g_deskew
        localparam int DEPTH = STAGES - 1 - gi;
        logic [SEG-1:0] ds_reg [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
              ds_reg[j] <= '0;
            end
          end else if (en) begin
            ds_reg[0] <= seg_s[LO +: SEG];
            for (int j = 1; j < DEPTH; j++) begin
              ds_reg[j] <= ds_reg[j-1];
            end
          end
        end

        assign sum_next[LO +: SEG] = ds_reg[DEPTH-1];
      end
    end
  endgenerate

  assign ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (seg_s[WIDTH-1] != op_a[WIDTH-1]);

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [MAX_WIDTH-1:0] SMAX = signed_max(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SMIN = signed_min(WIDTH);

  assign sum_fin = ovf_next ? (op_a[WIDTH-1] ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0]) : sum_next;
`else
  assign sum_fin = sum_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (en) begin
      vld_reg[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
      sum_reg   <= sum_fin;
      carry_reg <= cout_w[STAGES-1];
      ovf_reg   <= ovf_next;
    end
  end

  assign out_valid = vld_reg[STAGES-1];
  assign sum       = sum_reg;
  assign carry     = carry_reg;
  assign ovf       = ovf_reg;

endmodule
